// File: rtl/ex_result_pipe_pkg.sv
// Shared definitions for the post-execute result pipeline: ALU control codes,
// condition-code bit positions, the bubble fill value and the CCR update rule.
package ex_result_pipe_pkg;

  localparam logic [3:0] ALU_ADD  = 4'd1;
  localparam logic [3:0] ALU_ADC  = 4'd2;
  localparam logic [3:0] ALU_INC  = 4'd3;
  localparam logic [3:0] ALU_MOV  = 4'd4;
  localparam logic [3:0] ALU_DEC  = 4'd5;
  localparam logic [3:0] ALU_SUB  = 4'd6;
  localparam logic [3:0] ALU_SBB  = 4'd7;
  localparam logic [3:0] ALU_AND  = 4'd8;
  localparam logic [3:0] ALU_OR   = 4'd9;
  localparam logic [3:0] ALU_XOR  = 4'd10;
  localparam logic [3:0] ALU_SETC = 4'd11;
  localparam logic [3:0] ALU_CLRC = 4'd12;
  localparam logic [3:0] ALU_NOT  = 4'd13;
  localparam logic [3:0] ALU_LDI  = 4'd14;

  localparam int CCR_NEG   = 2;
  localparam int CCR_ZERO  = 1;
  localparam int CCR_CARRY = 0;

  // A bubble is an all-zero stage word: result 0, dst 0, wb 0, load 0.
  localparam logic BUBBLE_BIT = 1'b0;

  function automatic logic [2:0] ccr_next(input logic [2:0] cur,
                                          input logic [3:0] ctrl,
                                          input logic       neg,
                                          input logic       zero,
                                          input logic       carry);
    logic [2:0] nxt;
    nxt = cur;
    case (ctrl)
      ALU_ADD, ALU_ADC, ALU_INC, ALU_DEC, ALU_SUB,
      ALU_SBB, ALU_AND, ALU_OR, ALU_XOR: begin
        nxt[CCR_NEG]   = neg;
        nxt[CCR_ZERO]  = zero;
        nxt[CCR_CARRY] = carry;
      end
      ALU_SETC: nxt[CCR_CARRY] = 1'b1;
      ALU_CLRC: nxt[CCR_CARRY] = 1'b0;
      ALU_MOV, ALU_NOT, ALU_LDI: nxt = cur;
      default: nxt = cur;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/ex_result_pipe_pipe_stage_reg.sv
// One pipeline stage register: holds on stall, loads a bubble on flush,
// otherwise captures its input word.
module pipe_stage_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         stall_i,
  input  logic         flush_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  import ex_result_pipe_pkg::*;

  logic [W-1:0] data_d, data_q;

  always_comb begin
    data_d = data_q;
    if (!stall_i) begin
      data_d = flush_i ? {W{BUBBLE_BIT}} : d_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) data_q <= '0;
    else     data_q <= data_d;
  end

  assign q_o = data_q;

endmodule

// File: rtl/ex_result_pipe.sv
// Two-stage post-ALU result pipe (EX/MEM, MEM/WB) with forwarding taps,
// register-file write port, condition-code register and retire counter.
module ex_result_pipe #(
  parameter int N     = 16,
  parameter int REG_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             flush,
  input  logic [N-1:0]     alu_out,
  input  logic             alu_carry,
  input  logic             alu_zero,
  input  logic             alu_neg,
  input  logic [3:0]       alu_ctrl,
  input  logic [REG_W-1:0] dst_reg,
  input  logic             wb_en,
  input  logic             mem_read,
  input  logic [N-1:0]     mem_data,
  output logic [N-1:0]     result_prev1,
  output logic [N-1:0]     result_prev2,
  output logic [REG_W-1:0] reg2_buf2,
  output logic [REG_W-1:0] reg2_buf3,
  output logic             wb1,
  output logic             wb2,
  output logic             mem_read_load_case,
  output logic [2:0]       ccr,
  output logic             rf_we,
  output logic [REG_W-1:0] rf_waddr,
  output logic [15:0]      retired
);
  import ex_result_pipe_pkg::*;

  localparam int SW = N + REG_W + 2;

  logic [SW-1:0] s1_d, s1_q, s2_d, s2_q;
  logic          ld1, ld2;
  logic [2:0]    ccr_d, ccr_q;
  logic [15:0]   retired_d, retired_q;

  // Stage word layout: {result, dst, wb, load}.
  assign s1_d = {alu_out, dst_reg, wb_en, mem_read};
  assign {result_prev1, reg2_buf2, wb1, ld1} = s1_q;

  // A load picks up memory read data as it moves into stage 2.
  assign s2_d = {(ld1 ? mem_data : result_prev1), reg2_buf2, wb1, ld1};
  assign {result_prev2, reg2_buf3, wb2, ld2} = s2_q;

  pipe_stage_reg #(.W(SW)) u_stage1 (
    .clk     (clk),
    .rst     (rst),
    .stall_i (stall),
    .flush_i (flush),
    .d_i     (s1_d),
    .q_o     (s1_q)
  );

  pipe_stage_reg #(.W(SW)) u_stage2 (
    .clk     (clk),
    .rst     (rst),
    .stall_i (stall),
    .flush_i (1'b0),
    .d_i     (s2_d),
    .q_o     (s2_q)
  );

  // A flushed EX instruction never reaches the CCR.
  always_comb begin
    ccr_d = ccr_q;
    if (!stall && !flush) begin
      ccr_d = ccr_next(ccr_q, alu_ctrl, alu_neg, alu_zero, alu_carry);
    end
  end

  always_comb begin
    retired_d = retired_q;
    if (!stall && wb2) begin
      retired_d = retired_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ccr_q     <= 3'b000;
      retired_q <= 16'd0;
    end else begin
      ccr_q     <= ccr_d;
      retired_q <= retired_d;
    end
  end

  assign ccr                = ccr_q;
  assign retired            = retired_q;
  assign mem_read_load_case = ld2;
  assign rf_we              = wb2;
  assign rf_waddr           = reg2_buf3;

endmodule

// File: tb/tb_ex_result_pipe.sv
// Directed bench for ex_result_pipe: write-backs are predicted into a queue
// when issued and checked as they leave stage 2, plus spot checks of state.
module tb_ex_result_pipe;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        flush;
  logic [15:0] alu_out;
  logic        alu_carry, alu_zero, alu_neg;
  logic [3:0]  alu_ctrl;
  logic [2:0]  dst_reg;
  logic        wb_en;
  logic        mem_read;
  logic [15:0] mem_data;
  logic [15:0] result_prev1, result_prev2;
  logic [2:0]  reg2_buf2, reg2_buf3;
  logic        wb1, wb2, mem_read_load_case, rf_we;
  logic [2:0]  ccr;
  logic [2:0]  rf_waddr;
  logic [15:0] retired;

  typedef struct packed {
    logic [15:0] data;
    logic [2:0]  dst;
    logic        ld;
  } wb_t;

  wb_t sbQ[$];
  int  total = 0;
  int  bad = 0;
  bit  sbEnable = 1'b1;

  ex_result_pipe #(.N(16), .REG_W(3)) dut (
    .clk                (clk),
    .rst                (rst),
    .stall              (stall),
    .flush              (flush),
    .alu_out            (alu_out),
    .alu_carry          (alu_carry),
    .alu_zero           (alu_zero),
    .alu_neg            (alu_neg),
    .alu_ctrl           (alu_ctrl),
    .dst_reg            (dst_reg),
    .wb_en              (wb_en),
    .mem_read           (mem_read),
    .mem_data           (mem_data),
    .result_prev1       (result_prev1),
    .result_prev2       (result_prev2),
    .reg2_buf2          (reg2_buf2),
    .reg2_buf3          (reg2_buf3),
    .wb1                (wb1),
    .wb2                (wb2),
    .mem_read_load_case (mem_read_load_case),
    .ccr                (ccr),
    .rf_we              (rf_we),
    .rf_waddr           (rf_waddr),
    .retired            (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // flags packed as {neg, zero, carry}
  task automatic applyStimulus(input logic [3:0] ctrl, input logic [15:0] data,
                               input logic [2:0] dst, input logic wb, input logic ld,
                               input logic [2:0] flags);
    alu_ctrl  = ctrl;
    alu_out   = data;
    dst_reg   = dst;
    wb_en     = wb;
    mem_read  = ld;
    alu_neg   = flags[2];
    alu_zero  = flags[1];
    alu_carry = flags[0];
  endtask

  task automatic expectWb(input logic [15:0] data, input logic [2:0] dst, input logic ld);
    wb_t e;
    e.data = data;
    e.dst  = dst;
    e.ld   = ld;
    sbQ.push_back(e);
  endtask

  task automatic idle();
    applyStimulus(4'd0, 16'h0000, 3'd0, 1'b0, 1'b0, 3'b000);
  endtask

  // One clock; a fresh write-back leaving stage 2 is popped and compared.
  task automatic tick();
    bit  wasStall, wasRst;
    wb_t e;
    wasStall = stall;
    wasRst   = rst;
    @(posedge clk);
    #1;
    if (sbEnable && !wasStall && !wasRst && rf_we === 1'b1) begin
      if (sbQ.size() == 0) begin
        checkOutput("sb_unexpected_wb", 32'(sbQ.size()), 32'd1);
      end else begin
        e = sbQ.pop_front();
        checkOutput("wb_data", 32'(result_prev2), 32'(e.data));
        checkOutput("wb_addr", 32'(rf_waddr), 32'(e.dst));
        checkOutput("wb_load", 32'(mem_read_load_case), 32'(e.ld));
      end
    end
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0; mem_data = 16'h0000;
    idle();
    tick();
    tick();
    rst = 1'b0;
    checkOutput("rst_rp1", 32'(result_prev1), 32'd0);
    checkOutput("rst_rp2", 32'(result_prev2), 32'd0);
    checkOutput("rst_buf2", 32'(reg2_buf2), 32'd0);
    checkOutput("rst_wb1", 32'(wb1), 32'd0);
    checkOutput("rst_rfwe", 32'(rf_we), 32'd0);
    checkOutput("rst_ccr", 32'(ccr), 32'd0);
    checkOutput("rst_retired", 32'(retired), 32'd0);

    // Three back-to-back ADDs
    applyStimulus(4'd1, 16'h0005, 3'd1, 1'b1, 1'b0, 3'b000); expectWb(16'h0005, 3'd1, 1'b0);
    tick();
    checkOutput("add_rp1", 32'(result_prev1), 32'h0005);
    checkOutput("add_buf2", 32'(reg2_buf2), 32'd1);
    checkOutput("add_wb1", 32'(wb1), 32'd1);
    applyStimulus(4'd1, 16'h0006, 3'd2, 1'b1, 1'b0, 3'b000); expectWb(16'h0006, 3'd2, 1'b0);
    tick();
    checkOutput("add_rfwe", 32'(rf_we), 32'd1);
    checkOutput("add_rp2", 32'(result_prev2), 32'h0005);
    applyStimulus(4'd1, 16'h0007, 3'd3, 1'b1, 1'b0, 3'b000); expectWb(16'h0007, 3'd3, 1'b0);
    tick();
    idle();
    tick(); tick(); tick();
    checkOutput("add_retired", 32'(retired), 32'd3);

    // Load: memory data arrives for the edge that moves it into stage 2
    applyStimulus(4'd0, 16'h1234, 3'd4, 1'b1, 1'b1, 3'b000); expectWb(16'hBEEF, 3'd4, 1'b1);
    tick();
    idle();
    mem_data = 16'hBEEF;
    tick();
    checkOutput("ld_case", 32'(mem_read_load_case), 32'd1);
    checkOutput("ld_rp2", 32'(result_prev2), 32'hBEEF);
    mem_data = 16'h0000;
    tick();
    checkOutput("ld_retired", 32'(retired), 32'd4);

    // CCR updates
    applyStimulus(4'd6, 16'h0000, 3'd0, 1'b0, 1'b0, 3'b011); tick();
    checkOutput("ccr_sub", 32'(ccr), 32'b011);
    applyStimulus(4'd4, 16'h0000, 3'd0, 1'b0, 1'b0, 3'b100); tick();
    checkOutput("ccr_c4", 32'(ccr), 32'b011);
    applyStimulus(4'd13, 16'h0000, 3'd0, 1'b0, 1'b0, 3'b100); tick();
    checkOutput("ccr_c13", 32'(ccr), 32'b011);
    applyStimulus(4'd12, 16'h0000, 3'd0, 1'b0, 1'b0, 3'b101); tick();
    checkOutput("ccr_clrc", 32'(ccr), 32'b010);
    applyStimulus(4'd11, 16'h0000, 3'd0, 1'b0, 1'b0, 3'b000); tick();
    checkOutput("ccr_setc", 32'(ccr), 32'b011);
    applyStimulus(4'd3, 16'h0000, 3'd0, 1'b0, 1'b0, 3'b100); tick();
    checkOutput("ccr_c3", 32'(ccr), 32'b100);
    applyStimulus(4'd14, 16'h0000, 3'd0, 1'b0, 1'b0, 3'b011); tick();
    checkOutput("ccr_c14", 32'(ccr), 32'b100);
    applyStimulus(4'd10, 16'h0000, 3'd0, 1'b0, 1'b0, 3'b010); tick();
    checkOutput("ccr_c10", 32'(ccr), 32'b010);

    // Stall for three cycles with a flush pulse inside it
    applyStimulus(4'd1, 16'h0011, 3'd5, 1'b1, 1'b0, 3'b010); expectWb(16'h0011, 3'd5, 1'b0);
    tick();
    applyStimulus(4'd1, 16'h0022, 3'd6, 1'b1, 1'b0, 3'b001); expectWb(16'h0022, 3'd6, 1'b0);
    tick();
    stall = 1'b1;
    flush = 1'b1;
    applyStimulus(4'd6, 16'h0033, 3'd7, 1'b1, 1'b0, 3'b100);
    for (int k = 0; k < 3; k++) begin
      tick();
      checkOutput("stall_rp1", 32'(result_prev1), 32'h0022);
      checkOutput("stall_rp2", 32'(result_prev2), 32'h0011);
      checkOutput("stall_wb1", 32'(wb1), 32'd1);
      checkOutput("stall_rfaddr", 32'(rf_waddr), 32'd5);
      checkOutput("stall_ccr", 32'(ccr), 32'b001);
      checkOutput("stall_retired", 32'(retired), 32'd4);
    end
    stall = 1'b0;
    flush = 1'b0;
    idle();
    tick();
    checkOutput("unstall_retired", 32'(retired), 32'd5);
    tick();
    checkOutput("unstall_retired2", 32'(retired), 32'd6);

    // Flush on a ctrl=5 write-back instruction
    applyStimulus(4'd1, 16'h0044, 3'd1, 1'b1, 1'b0, 3'b000); expectWb(16'h0044, 3'd1, 1'b0);
    tick();
    applyStimulus(4'd5, 16'h0055, 3'd2, 1'b1, 1'b0, 3'b111);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checkOutput("flush_wb1", 32'(wb1), 32'd0);
    checkOutput("flush_rp1", 32'(result_prev1), 32'd0);
    checkOutput("flush_buf2", 32'(reg2_buf2), 32'd0);
    checkOutput("flush_ccr", 32'(ccr), 32'b000);
    checkOutput("flush_older_we", 32'(rf_we), 32'd1);
    idle();
    tick(); tick();
    checkOutput("flush_retired", 32'(retired), 32'd7);

    // Bulk write-backs to bring the counter to 0xFFFF, then wrap
    sbEnable = 1'b0;
    for (int i = 0; i < 65528; i++) begin
      applyStimulus(4'd0, 16'(i), 3'(i), 1'b1, 1'b0, 3'b000);
      tick();
    end
    idle();
    tick(); tick(); tick();
    sbEnable = 1'b1;
    checkOutput("retired_max", 32'(retired), 32'hFFFF);
    applyStimulus(4'd0, 16'hABCD, 3'd3, 1'b1, 1'b0, 3'b000); expectWb(16'hABCD, 3'd3, 1'b0);
    tick();
    idle();
    tick(); tick(); tick();
    checkOutput("retired_wrap", 32'(retired), 32'h0000);

    // Reset mid-stream overrides stall and flush
    applyStimulus(4'd1, 16'h0077, 3'd2, 1'b1, 1'b0, 3'b100); expectWb(16'h0077, 3'd2, 1'b0);
    tick();
    applyStimulus(4'd1, 16'h0088, 3'd3, 1'b1, 1'b0, 3'b100); expectWb(16'h0088, 3'd3, 1'b0);
    tick();
    applyStimulus(4'd1, 16'h0099, 3'd4, 1'b1, 1'b0, 3'b100);
    tick();
    checkOutput("pre_rst_retired", 32'(retired), 32'd1);
    checkOutput("pre_rst_ccr", 32'(ccr), 32'b100);
    rst = 1'b1; stall = 1'b1; flush = 1'b1;
    tick();
    checkOutput("mrst_rp1", 32'(result_prev1), 32'd0);
    checkOutput("mrst_rp2", 32'(result_prev2), 32'd0);
    checkOutput("mrst_buf2", 32'(reg2_buf2), 32'd0);
    checkOutput("mrst_buf3", 32'(reg2_buf3), 32'd0);
    checkOutput("mrst_wb1", 32'(wb1), 32'd0);
    checkOutput("mrst_wb2", 32'(wb2), 32'd0);
    checkOutput("mrst_ld", 32'(mem_read_load_case), 32'd0);
    checkOutput("mrst_ccr", 32'(ccr), 32'd0);
    checkOutput("mrst_retired", 32'(retired), 32'd0);
    rst = 1'b0; stall = 1'b0; flush = 1'b0;
    idle();
    tick();
    checkOutput("sb_drained", 32'(sbQ.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
